// File: rtl/videomem_arb_pkg.sv
// Shared types and widths for the video-memory arbiter slice.
// Owner codes double as the externally visible grant value.
package videomem_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INIT = 2'd1,
        GNT_USB  = 2'd2,
        GNT_DISP = 2'd3
    } owner_t;

endpackage

// File: rtl/videomem_arbiter_if.sv
// Client and SDRAM-controller handshake bundle for videomem_arbiter.
// slave = arbiter view, master = clients plus controller view.
interface videomem_arbiter_if;
    import videomem_arb_pkg::*;

    logic              init_wr_req;
    logic [ADDR_W-1:0] init_wr_addr;
    logic [DATA_W-1:0] init_wr_data;
    logic              init_req_ack;
    logic              init_next_data;

    logic              usb_wr_req;
    logic [ADDR_W-1:0] usb_wr_addr;
    logic [DATA_W-1:0] usb_wr_data;
    logic              usb_req_ack;
    logic              usb_next_data;

    logic              disp_rd_req;
    logic [ADDR_W-1:0] disp_rd_addr;
    logic              disp_req_ack;
    logic              disp_rd_valid;
    logic [DATA_W-1:0] disp_rd_data;

    logic              mem_req;
    logic              mem_req_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_req_ack;
    logic              mem_give_next_data;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  init_wr_req, init_wr_addr, init_wr_data,
        input  usb_wr_req, usb_wr_addr, usb_wr_data,
        input  disp_rd_req, disp_rd_addr,
        input  mem_req_ack, mem_give_next_data, mem_rd_valid, mem_rd_data,
        output init_req_ack, init_next_data,
        output usb_req_ack, usb_next_data,
        output disp_req_ack, disp_rd_valid, disp_rd_data,
        output mem_req, mem_req_wr, mem_addr, mem_wr_data
    );

    modport master (
        output init_wr_req, init_wr_addr, init_wr_data,
        output usb_wr_req, usb_wr_addr, usb_wr_data,
        output disp_rd_req, disp_rd_addr,
        output mem_req_ack, mem_give_next_data, mem_rd_valid, mem_rd_data,
        input  init_req_ack, init_next_data,
        input  usb_req_ack, usb_next_data,
        input  disp_req_ack, disp_rd_valid, disp_rd_data,
        input  mem_req, mem_req_wr, mem_addr, mem_wr_data
    );

endinterface

// File: rtl/videomem_arb_pick.sv
// Combinational owner selection for the next burst.
// Init owns the port until init_complete; afterwards display beats USB unless USB is starved.
module videomem_arb_pick
    import videomem_arb_pkg::*;
(
    input  logic   init_req,
    input  logic   usb_req,
    input  logic   disp_req,
    input  logic   init_complete,
    input  logic   starved,
    output owner_t pick
);

    always_comb begin
        pick = GNT_NONE;
        if (!init_complete) begin
            if (init_req) pick = GNT_INIT;
        end else if (usb_req && starved) begin
            pick = GNT_USB;
        end else if (disp_req) begin
            pick = GNT_DISP;
        end else if (usb_req) begin
            pick = GNT_USB;
        end
    end

endmodule

// File: rtl/videomem_arbiter.sv
// Three-way arbiter in front of the SDRAM controller request port; one burst per grant.
// Owner keeps the port from grant through its last data beat; at least one IDLE cycle between bursts.
module videomem_arbiter
    import videomem_arb_pkg::*;
#(
    parameter int BURST_LEN    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                mem_clock,
    input  logic                reset,
    input  logic                mem_ready,
    input  logic                init_complete,
    videomem_arbiter_if.slave   bus,
    output logic [1:0]          grant,
    output logic                busy,
    output logic                proto_err
);

    localparam logic [3:0] LAST_BEAT  = 4'(BURST_LEN - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    owner_t     grant_q, grant_d;
    logic [3:0] beat_q, beat_d;
    logic [3:0] starve_q, starve_d;
    logic       proto_err_q, proto_err_d;

    owner_t     pick;
    logic       owner_beat;
    logic       any_beat;

    videomem_arb_pick u_pick (
        .init_req      (bus.init_wr_req),
        .usb_req       (bus.usb_wr_req),
        .disp_req      (bus.disp_rd_req),
        .init_complete (init_complete),
        .starved       (starve_q == STARVE_MAX),
        .pick          (pick)
    );

    // Writers count give_next_data strobes, the display counts rd_valid strobes.
    assign owner_beat = (grant_q == GNT_DISP) ? bus.mem_rd_valid : bus.mem_give_next_data;
    assign any_beat   = bus.mem_give_next_data | bus.mem_rd_valid;

    always_ff @(posedge mem_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= GNT_NONE;
            beat_q      <= '0;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            beat_q      <= beat_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        beat_d      = beat_q;
        starve_d    = starve_q;
        proto_err_d = proto_err_q | (any_beat & (state_q != XFER));

        unique case (state_q)
            IDLE: begin
                if (mem_ready && (pick != GNT_NONE)) begin
                    state_d = REQ;
                    grant_d = pick;
                    if (pick == GNT_USB) begin
                        starve_d = '0;
                    end else if ((pick == GNT_DISP) && bus.usb_wr_req && (starve_q < STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ack) begin
                    state_d = XFER;
                    beat_d  = '0;
                end
            end
            XFER: begin
                if (owner_beat) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        grant_d = GNT_NONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
                beat_d  = '0;
            end
        endcase

        // Controller losing init flushes the burst; starvation history and errors survive.
        if (!mem_ready) begin
            state_d = IDLE;
            grant_d = GNT_NONE;
            beat_d  = '0;
        end
    end

    always_comb begin
        logic in_req;
        logic in_xfer;

        in_req  = (state_q == REQ);
        in_xfer = (state_q == XFER);

        bus.mem_req        = in_req;
        bus.mem_req_wr     = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wr_data    = '0;
        bus.init_req_ack   = 1'b0;
        bus.init_next_data = 1'b0;
        bus.usb_req_ack    = 1'b0;
        bus.usb_next_data  = 1'b0;
        bus.disp_req_ack   = 1'b0;
        bus.disp_rd_valid  = 1'b0;
        bus.disp_rd_data   = bus.mem_rd_data;

        if (in_req || in_xfer) begin
            unique case (grant_q)
                GNT_INIT: begin
                    bus.mem_req_wr     = 1'b1;
                    bus.mem_addr       = bus.init_wr_addr;
                    bus.mem_wr_data    = bus.init_wr_data;
                    bus.init_req_ack   = bus.mem_req_ack & in_req;
                    bus.init_next_data = bus.mem_give_next_data & in_xfer;
                end
                GNT_USB: begin
                    bus.mem_req_wr     = 1'b1;
                    bus.mem_addr       = bus.usb_wr_addr;
                    bus.mem_wr_data    = bus.usb_wr_data;
                    bus.usb_req_ack    = bus.mem_req_ack & in_req;
                    bus.usb_next_data  = bus.mem_give_next_data & in_xfer;
                end
                GNT_DISP: begin
                    bus.mem_addr       = bus.disp_rd_addr;
                    bus.disp_req_ack   = bus.mem_req_ack & in_req;
                    bus.disp_rd_valid  = bus.mem_rd_valid & in_xfer;
                end
                default: ;
            endcase
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_videomem_arbiter.sv
// Directed bench for videomem_arbiter: a small controller model serves each burst and
// checks ownership, strobes and forwarded data against hand-computed values.
module tb_videomem_arbiter;
    import videomem_arb_pkg::*;

    localparam int BURST  = 4;
    localparam int STARVE = 8;

    localparam logic [24:0] INIT_A = 25'h0000100;
    localparam logic [24:0] USB_A  = 25'h1ABCDE0;
    localparam logic [24:0] DISP_A = 25'h0F00040;
    localparam logic [31:0] INIT_D = 32'h1111_0000;
    localparam logic [31:0] USB_D  = 32'hC0DE_0000;
    localparam logic [31:0] RD_D   = 32'hA5A5_0000;

    logic       mem_clock = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b0;
    logic       init_complete = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       proto_err;

    int checks = 0;
    int failures = 0;

    videomem_arbiter_if bus ();

    videomem_arbiter #(
        .BURST_LEN    (BURST),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .mem_clock     (mem_clock),
        .reset         (reset),
        .mem_ready     (mem_ready),
        .init_complete (init_complete),
        .bus           (bus),
        .grant         (grant),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    always #5 mem_clock = ~mem_clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {init, usb, disp} strobe vector expected for a given owner
    function automatic logic [2:0] hot(input logic [1:0] g);
        case (g)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [24:0] addr_of(input logic [1:0] g);
        case (g)
            2'd1:    return INIT_A;
            2'd2:    return USB_A;
            2'd3:    return DISP_A;
            default: return 25'd0;
        endcase
    endfunction

    // Controller model: acks ack_dly cycles after mem_req rises, then delivers BURST beats.
    // abort_beat >= 0 drops mem_ready together with that beat and returns after checking the flush.
    task automatic serve(input logic [1:0] exp_g, input int ack_dly, input bit drop_in_req,
                         input int abort_beat, input string tag);
        int n;
        int req_cyc;
        logic [2:0] exp_hot;
        logic [31:0] exp_wd;
        exp_hot = hot(exp_g);
        n = 0;
        while (!bus.mem_req && n < 40) begin
            @(negedge mem_clock);
            n++;
        end
        check_val({tag, "_req_seen"}, 32'(bus.mem_req), 32'd1);
        if (!bus.mem_req) return;
        check_val({tag, "_grant"}, 32'(grant), 32'(exp_g));
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_req_wr"}, 32'(bus.mem_req_wr), (exp_g == 2'd3) ? 32'd0 : 32'd1);
        check_val({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr_of(exp_g)));
        if (drop_in_req) begin
            bus.init_wr_req = 1'b0;
            bus.usb_wr_req  = 1'b0;
            bus.disp_rd_req = 1'b0;
        end
        req_cyc = 0;
        while (bus.mem_req && req_cyc < 40) begin
            bus.mem_req_ack = (req_cyc == ack_dly);
            #1;
            check_val({tag, "_req_ack"}, 32'({bus.init_req_ack, bus.usb_req_ack, bus.disp_req_ack}),
                      bus.mem_req_ack ? 32'(exp_hot) : 32'd0);
            req_cyc++;
            @(negedge mem_clock);
        end
        bus.mem_req_ack = 1'b0;
        check_val({tag, "_req_cycles"}, 32'(req_cyc), 32'(ack_dly + 1));
        for (int b = 0; b < BURST; b++) begin
            exp_wd = 32'd0;
            if (exp_g == 2'd3) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = RD_D + 32'(b);
            end else begin
                bus.mem_give_next_data = 1'b1;
                if (exp_g == 2'd1) begin
                    bus.init_wr_data = INIT_D + 32'(b);
                    exp_wd = INIT_D + 32'(b);
                end else begin
                    bus.usb_wr_data = USB_D + 32'(b);
                    exp_wd = USB_D + 32'(b);
                end
            end
            if (b == abort_beat) mem_ready = 1'b0;
            #1;
            check_val({tag, "_beat_strobe"},
                      32'({bus.init_next_data, bus.usb_next_data, bus.disp_rd_valid}), 32'(exp_hot));
            if (exp_g == 2'd3)
                check_val({tag, "_rd_data"}, bus.disp_rd_data, RD_D + 32'(b));
            else
                check_val({tag, "_wr_data"}, bus.mem_wr_data, exp_wd);
            @(negedge mem_clock);
            bus.mem_rd_valid = 1'b0;
            bus.mem_give_next_data = 1'b0;
            if (b == abort_beat) begin
                check_val({tag, "_flush_grant"}, 32'(grant), 32'd0);
                check_val({tag, "_flush_req"}, 32'(bus.mem_req), 32'd0);
                check_val({tag, "_flush_busy"}, 32'(busy), 32'd0);
                return;
            end
        end
        check_val({tag, "_end_grant"}, 32'(grant), 32'd0);
        check_val({tag, "_end_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_end_addr"}, 32'(bus.mem_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [1:0] eg;

        bus.init_wr_req = 1'b0;  bus.init_wr_addr = INIT_A;  bus.init_wr_data = 32'hDEAD_0001;
        bus.usb_wr_req  = 1'b0;  bus.usb_wr_addr  = USB_A;   bus.usb_wr_data  = 32'hDEAD_0002;
        bus.disp_rd_req = 1'b0;  bus.disp_rd_addr = DISP_A;
        bus.mem_req_ack = 1'b0;  bus.mem_give_next_data = 1'b0;
        bus.mem_rd_valid = 1'b0; bus.mem_rd_data = 32'd0;

        repeat (3) @(negedge mem_clock);
        #1;
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_proto_err", 32'(proto_err), 32'd0);
        check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rst_acks", 32'({bus.init_req_ack, bus.usb_req_ack, bus.disp_req_ack}), 32'd0);
        check_val("rst_addr", 32'(bus.mem_addr), 32'd0);
        @(negedge mem_clock);
        reset = 1'b0;
        mem_ready = 1'b1;

        // Before init_complete only the pattern writer may own the port.
        bus.init_wr_req = 1'b1;
        bus.usb_wr_req  = 1'b1;
        bus.disp_rd_req = 1'b1;
        serve(2'd1, 0, 1'b0, -1, "init0");
        serve(2'd1, 1, 1'b0, -1, "init1");

        // Continuous display + USB: 8 display grants, then one forced USB grant.
        init_complete = 1'b1;
        st = 0;
        for (int k = 0; k < 18; k++) begin
            if (st == STARVE) begin
                eg = 2'd2;
                st = 0;
            end else begin
                eg = 2'd3;
                st++;
            end
            serve(eg, 0, 1'b0, -1, (eg == 2'd2) ? "starve_usb" : "starve_disp");
        end
        bus.init_wr_req = 1'b0;
        bus.usb_wr_req  = 1'b0;
        bus.disp_rd_req = 1'b0;
        @(negedge mem_clock);
        check_val("quiet_grant", 32'(grant), 32'd0);

        // Single USB write, ack three cycles late, request dropped during REQ.
        bus.usb_wr_req = 1'b1;
        #1;
        check_val("usb_pre_req", 32'(bus.mem_req), 32'd0);
        @(negedge mem_clock);
        check_val("usb_latency", 32'(bus.mem_req), 32'd1);
        serve(2'd2, 3, 1'b1, -1, "usb");

        bus.disp_rd_req = 1'b1;
        serve(2'd3, 1, 1'b1, -1, "disp");

        // mem_ready lost on beat 2 of a USB write, then a fresh burst.
        bus.usb_wr_req = 1'b1;
        serve(2'd2, 0, 1'b0, 1, "abort");
        @(negedge mem_clock);
        check_val("abort_hold_grant", 32'(grant), 32'd0);
        check_val("abort_hold_req", 32'(bus.mem_req), 32'd0);
        mem_ready = 1'b1;
        @(negedge mem_clock);
        check_val("abort_regrant_req", 32'(bus.mem_req), 32'd1);
        check_val("abort_regrant_grant", 32'(grant), 32'd2);
        serve(2'd2, 0, 1'b1, -1, "retry");
        check_val("retry_proto_err", 32'(proto_err), 32'd0);

        // Stray beat while idle is dropped and latched as a protocol error.
        bus.mem_give_next_data = 1'b1;
        #1;
        check_val("stray_strobes", 32'({bus.init_next_data, bus.usb_next_data, bus.disp_rd_valid}), 32'd0);
        @(negedge mem_clock);
        bus.mem_give_next_data = 1'b0;
        check_val("stray_proto_err", 32'(proto_err), 32'd1);
        check_val("stray_busy", 32'(busy), 32'd0);
        bus.disp_rd_req = 1'b1;
        serve(2'd3, 2, 1'b1, -1, "post_err");
        check_val("sticky_proto_err", 32'(proto_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
